// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable / divided-waveform generator with settle-qualified lock.
// Every accepted reconfiguration (and every reset) restarts a common settle window,
// after which all channels restart together from a shared time origin.
module clk_div_gen #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned DIV_INIT    = 2,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
);

    localparam int unsigned SET_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [SET_W-1:0]   r_settle_cnt;
    logic [SET_W-1:0]   w_next_settle;
    logic               w_go_run;
    logic               w_cfg_apply;
    logic               w_cfg_err;
    logic               w_cfg_ok;
    logic [DIV_W-1:0]   w_cfg_div_eff;

    logic [DIV_W-1:0]   r_div   [NUM_CH];
    logic [DIV_W-1:0]   r_phase [NUM_CH];
    logic [DIV_W-1:0]   r_cnt   [NUM_CH];
    logic [DIV_W-1:0]   w_cnt_nxt [NUM_CH];
    logic [DIV_W-1:0]   w_half    [NUM_CH];

    logic [NUM_CH-1:0]  r_clk_en;
    logic [NUM_CH-1:0]  r_clk_out;
    logic               r_locked;
    logic               r_cfg_err;

    // State and settle-counter register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_next_state;
            r_settle_cnt <= w_next_settle;
        end
    end

    // Next-state, settle counting and configuration decode
    always_comb begin
        w_next_state  = r_state;
        w_next_settle = r_settle_cnt;
        w_go_run      = 1'b0;
        w_cfg_apply   = 1'b0;
        w_cfg_err     = 1'b0;
        w_cfg_div_eff = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
        w_cfg_ok      = (32'(cfg_ch) < NUM_CH) && (cfg_phase < w_cfg_div_eff);
        case (r_state)
            ST_SETTLE: begin
                // The count holds the number of completed settle cycles.
                if (r_settle_cnt == SET_W'(LOCK_CYCLES)) begin
                    w_next_state = ST_RUN;
                    w_go_run     = 1'b1;
                end else begin
                    w_next_settle = r_settle_cnt + SET_W'(1);
                end
            end
            ST_RUN: begin
                if (cfg_valid) begin
                    if (w_cfg_ok) begin
                        w_cfg_apply   = 1'b1;
                        w_next_state  = ST_SETTLE;
                        w_next_settle = '0;
                    end else begin
                        w_cfg_err = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state  = ST_SETTLE;
                w_next_settle = '0;
            end
        endcase
    end

    // Per-channel next count: phase-offset start on lock, else wrap 0..div-1
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_half[i] = (r_div[i] >> 1) + DIV_W'(r_div[i][0]);
            if (w_go_run) begin
                w_cnt_nxt[i] = (r_phase[i] == '0) ? '0 : r_div[i] - r_phase[i];
            end else begin
                w_cnt_nxt[i] = (r_cnt[i] == r_div[i] - DIV_W'(1)) ? '0 : r_cnt[i] + DIV_W'(1);
            end
        end
    end

    // Channel configuration, counters and registered outputs
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i]   <= DIV_W'(DIV_INIT);
                r_phase[i] <= '0;
                r_cnt[i]   <= '0;
            end
            r_clk_en  <= '0;
            r_clk_out <= '0;
            r_locked  <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_locked  <= (w_next_state == ST_RUN);
            r_cfg_err <= w_cfg_err;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_cfg_apply && (cfg_ch == CH_W'(i))) begin
                    r_div[i]   <= w_cfg_div_eff;
                    r_phase[i] <= cfg_phase;
                end
                if (w_next_state == ST_RUN) begin
                    r_cnt[i]     <= w_cnt_nxt[i];
                    r_clk_en[i]  <= (w_cnt_nxt[i] == '0);
                    r_clk_out[i] <= (w_cnt_nxt[i] < w_half[i]);
                end else begin
                    r_clk_en[i]  <= 1'b0;
                    r_clk_out[i] <= 1'b0;
                end
            end
        end
    end

    assign clk_en    = r_clk_en;
    assign clk_out   = r_clk_out;
    assign locked    = r_locked;
    assign cfg_ready = r_locked;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen (NUM_CH=2, DIV_W=8, LOCK_CYCLES=16, DIV_INIT=2).
module tb_clk_div_gen;

    localparam int LOCK = 16;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [7:0] cfg_phase;
    logic       cfg_err;
    logic [1:0] clk_en;
    logic [1:0] clk_out;
    logic       locked;

    clk_div_gen #(
        .NUM_CH(2), .DIV_W(8), .LOCK_CYCLES(LOCK), .DIV_INIT(2)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
        .cfg_err(cfg_err), .clk_en(clk_en), .clk_out(clk_out), .locked(locked)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int errs   = 0;
    int checks = 0;

    // Reference model: the waveform is a pure function of time since the common origin.
    int cyc = 0;
    int t0  = 1 << 30;
    int mdiv [2];
    int mph  [2];
    bit m_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic void exp_ch(input int c, input int p, output bit en, output bit out);
        int k;
        en  = 1'b0;
        out = 1'b0;
        if (p >= t0) begin
            k   = ((p - t0) + mdiv[c] - mph[c]) % mdiv[c];
            en  = (k == 0);
            out = (k < (mdiv[c] + 1) / 2);
        end
    endfunction

    // One clock: drive inputs, advance model on the edge, compare just after it.
    task automatic step(input bit rst, input bit v, input int ch, input int dv, input int ph);
        int  eff;
        bit  en0, en1, o0, o1;
        sys_rst_n = rst;
        cfg_valid = v;
        cfg_ch    = 1'(ch);
        cfg_div   = 8'(dv);
        cfg_phase = 8'(ph);
        @(posedge sys_clk);
        cyc++;
        m_err = 1'b0;
        if (!rst) begin
            mdiv[0] = 2; mdiv[1] = 2;
            mph[0]  = 0; mph[1]  = 0;
            t0 = cyc + LOCK + 1;
        end else if (v && (cyc - 1 >= t0)) begin
            eff = (dv == 0) ? 1 : dv;
            if (ch < 2 && ph < eff) begin
                mdiv[ch] = eff;
                mph[ch]  = ph;
                t0 = cyc + LOCK + 1;
            end else begin
                m_err = 1'b1;
            end
        end
        #1;
        exp_ch(0, cyc, en0, o0);
        exp_ch(1, cyc, en1, o1);
        chk("locked",    int'(locked),    int'(cyc >= t0));
        chk("cfg_ready", int'(cfg_ready), int'(cyc >= t0));
        chk("cfg_err",   int'(cfg_err),   int'(m_err));
        chk("clk_en",    int'(clk_en),    int'({en1, en0}));
        chk("clk_out",   int'(clk_out),   int'({o1, o0}));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 100) begin
            step(1, 0, 0, 0, 0);
            n++;
        end
        if (n >= 100) chk("ready_timeout", int'(cfg_ready), 1);
    endtask

    task automatic send(input int ch, input int dv, input int ph);
        wait_ready();
        step(1, 1, ch, dv, ph);
    endtask

    typedef struct {
        int ch;
        int dv;
        int ph;
        int run;
        bit exp_err;
    } vec_t;

    vec_t vecs [10];
    int   n_lock;
    int   pat_en0 [10];
    int   pat_en1 [10];

    initial begin
        vecs[0] = '{ch: 1, dv: 5,   ph: 0,   run: 30, exp_err: 1'b0};
        vecs[1] = '{ch: 1, dv: 4,   ph: 1,   run: 30, exp_err: 1'b0};
        vecs[2] = '{ch: 1, dv: 4,   ph: 6,   run: 8,  exp_err: 1'b1};
        vecs[3] = '{ch: 1, dv: 4,   ph: 4,   run: 8,  exp_err: 1'b1};
        vecs[4] = '{ch: 0, dv: 0,   ph: 0,   run: 25, exp_err: 1'b0};
        vecs[5] = '{ch: 0, dv: 1,   ph: 0,   run: 25, exp_err: 1'b0};
        vecs[6] = '{ch: 0, dv: 0,   ph: 1,   run: 6,  exp_err: 1'b1};
        vecs[7] = '{ch: 0, dv: 7,   ph: 6,   run: 30, exp_err: 1'b0};
        vecs[8] = '{ch: 1, dv: 255, ph: 254, run: 40, exp_err: 1'b0};
        vecs[9] = '{ch: 1, dv: 3,   ph: 2,   run: 20, exp_err: 1'b0};

        sys_rst_n = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_phase = '0;

        // Reset state
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Lock latency from the first edge with reset released, then div-2 pattern
        n_lock = 0;
        do begin
            step(1, 0, 0, 0, 0);
            n_lock++;
        end while (locked !== 1'b1 && n_lock < 100);
        chk("lock_latency", n_lock, LOCK + 1);
        for (int i = 0; i < 6; i++) begin
            chk("t1_en",  int'(clk_en),  (i % 2 == 0) ? 3 : 0);
            chk("t1_out", int'(clk_out), (i % 2 == 0) ? 3 : 0);
            step(1, 0, 0, 0, 0);
        end

        // Table of configuration requests
        foreach (vecs[v]) begin
            send(vecs[v].ch, vecs[v].dv, vecs[v].ph);
            chk("tbl_err",  int'(cfg_err), int'(vecs[v].exp_err));
            chk("tbl_lock", int'(locked),  int'(vecs[v].exp_err));
            idle(vecs[v].run);
        end

        // Explicit phase alignment: ch0 div2, ch1 div4 phase1
        send(0, 2, 0);
        send(1, 4, 1);
        wait_ready();
        pat_en0 = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
        pat_en1 = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
        for (int i = 0; i < 10; i++) begin
            chk("t3_en0", int'(clk_en[0]), pat_en0[i]);
            chk("t3_en1", int'(clk_en[1]), pat_en1[i]);
            step(1, 0, 0, 0, 0);
        end

        // Mid-run reset with ch1 at div 5
        send(1, 5, 0);
        wait_ready();
        idle(7);
        step(0, 0, 0, 0, 0);
        chk("rst_en",   int'(clk_en),  0);
        chk("rst_out",  int'(clk_out), 0);
        chk("rst_lock", int'(locked),  0);
        wait_ready();
        chk("rst_relock_en", int'(clk_en), 3);
        step(1, 0, 0, 0, 0);
        chk("rst_relock_en2", int'(clk_en), 0);

        // Reset together with a valid request: the request is dropped
        send(1, 3, 0);
        wait_ready();
        step(0, 1, 1, 5, 0);
        wait_ready();
        idle(4);
        chk("rst_wins_en1", int'(clk_en[1]), 1);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 19) == 0),
                 int'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 8)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
